// File: rtl/voice_mixer.sv
// voice_mixer: sums masked voice samples one per clock, normalises, scales by a slewed master volume.
// Optional macro MIXER_SATURATE_EN: clip the voice sum at full scale instead of dividing by 2^(SW-AW).
package CONFIG;
  localparam int AUDIO_BIT_WIDTH = 16;
  localparam int PERCENT_WIDTH   = 8;
endpackage

package PARAMETER;
  typedef struct packed {
    logic [CONFIG::PERCENT_WIDTH-1:0] volume;
  } parameter_t;
endpackage

module voice_mixer #(
  parameter int VOICE_COUNT = 4,
  parameter int RAMP_STEP   = 1
) (
  input  logic                                                i_clock,
  input  logic                                                i_reset,
  input  PARAMETER::parameter_t                               i_parameters,
  input  logic                                                i_sample_tick,
  input  logic [VOICE_COUNT-1:0][CONFIG::AUDIO_BIT_WIDTH-1:0] i_voice_audios,
  input  logic [VOICE_COUNT-1:0]                              i_voice_active,
  output logic [CONFIG::AUDIO_BIT_WIDTH-1:0]                  o_audio_out,
  output logic                                                o_audio_valid,
  output logic                                                o_busy,
  output logic                                                o_overrun
);
  localparam int AW = CONFIG::AUDIO_BIT_WIDTH;
  localparam int PW = CONFIG::PERCENT_WIDTH;
  localparam int CW = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;
  localparam int SW = AW + CW;
  localparam logic [31:0] STEP = 32'(RAMP_STEP);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE} state_t;

  state_t                         r_state;
  logic [VOICE_COUNT-1:0][AW-1:0] r_snap;
  logic [VOICE_COUNT-1:0]         r_snap_active;
  logic [SW-1:0]                  r_acc;
  logic [CW-1:0]                  r_idx;
  logic [PW-1:0]                  r_vol;
  logic [AW-1:0]                  r_out;
  logic                           r_valid;
  logic                           r_busy;
  logic                           r_overrun;

  logic [PW-1:0]    w_target;
  logic [PW-1:0]    w_vol_next;
  logic [31:0]      w_up_gap;
  logic [31:0]      w_dn_gap;
  logic [AW-1:0]    w_mixed;
  logic [AW+PW-1:0] w_product;
  logic [SW-1:0]    w_addend;

  assign w_target = i_parameters.volume;
  assign w_up_gap = 32'(w_target) - 32'(r_vol);
  assign w_dn_gap = 32'(r_vol) - 32'(w_target);

  // Step toward the target; a gap no larger than one step lands exactly on it.
  always_comb begin
    w_vol_next = w_target;
    if (RAMP_STEP != 0) begin
      if (w_target > r_vol && w_up_gap > STEP)
        w_vol_next = r_vol + STEP[PW-1:0];
      else if (w_target < r_vol && w_dn_gap > STEP)
        w_vol_next = r_vol - STEP[PW-1:0];
    end
  end

`ifdef MIXER_SATURATE_EN
  assign w_mixed = (|r_acc[SW-1:AW]) ? {AW{1'b1}} : r_acc[AW-1:0];
`else
  assign w_mixed = r_acc[SW-1 -: AW];
`endif

  assign w_product = (AW+PW)'(w_mixed) * (AW+PW)'(r_vol);
  assign w_addend  = r_snap_active[r_idx] ? SW'(r_snap[r_idx]) : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_snap        <= '0;
      r_snap_active <= '0;
      r_acc         <= '0;
      r_idx         <= '0;
      r_vol         <= '0;
      r_out         <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_sample_tick) begin
            r_snap        <= i_voice_audios;
            r_snap_active <= i_voice_active;
            r_acc         <= '0;
            r_idx         <= '0;
            r_vol         <= w_vol_next;
            r_busy        <= 1'b1;
            r_state       <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_addend;
          r_idx <= r_idx + 1'b1;
          if (r_idx == CW'(VOICE_COUNT-1))
            r_state <= S_SCALE;
        end
        S_SCALE: begin
          r_out   <= w_product[AW+PW-1 -: AW];
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // Ticks arriving mid-pass are dropped but remembered.
      if (i_sample_tick && r_state != S_IDLE)
        r_overrun <= 1'b1;
    end
  end

  assign o_audio_out   = r_out;
  assign o_audio_valid = r_valid;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;

endmodule
